// File: rtl/pinmux_ctl.sv
// pinmux_ctl: memory-mapped pad multiplexer. Per-pin function select,
// output inversion and force-input; 2-flop input synchronisers feeding a
// per-pin glitch filter with a shared length; sticky rising-edge flags and a
// write-once configuration lock.
//
// Bus strobes: mem_we and mem_re are single-cycle qualifiers with no
// back-pressure. A write commits on the rising edge where mem_we is high. A
// read returns mem_rdata combinationally in the same cycle that mem_re is high.
// That data reflects register state before the coming edge.
module pinmux_ctl #(
  parameter logic [31:0]           PINMUX_BASE_ADDR = 32'h40006000,
  parameter int                    NUM_PINS         = 8,
  parameter int                    NUM_FUNC         = 4,
  parameter int                    FILT_W           = 4,
  parameter logic [NUM_PINS*4-1:0] RESET_SEL        = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic                         mem_we,
  input  logic                         mem_re,
  output logic [31:0]                  mem_rdata,
  input  logic [NUM_PINS*NUM_FUNC-1:0] func_out,
  input  logic [NUM_PINS*NUM_FUNC-1:0] func_oe,
  input  logic [NUM_PINS-1:0]          pad_in,
  output logic [NUM_PINS-1:0]          pad_out,
  output logic [NUM_PINS-1:0]          pad_oe,
  output logic [NUM_PINS-1:0]          pin_in
);

  localparam logic [5:0] OFF_FILT = 6'h10;
  localparam logic [5:0] OFF_IN   = 6'h11;
  localparam logic [5:0] OFF_EDGE = 6'h12;
  localparam logic [5:0] OFF_LOCK = 6'h13;

  // Configuration state
  logic [3:0]          r_sel [NUM_PINS];
  logic [NUM_PINS-1:0] r_force;
  logic [NUM_PINS-1:0] r_inv;
  logic [FILT_W-1:0]   r_filt_n;
  logic                r_lock;
  logic [NUM_PINS-1:0] r_edge;

  // Input path state
  logic [NUM_PINS-1:0] r_s1;
  logic [NUM_PINS-1:0] r_s2;
  logic [NUM_PINS-1:0] r_filt;
  logic [FILT_W-1:0]   r_cnt [NUM_PINS];

  // Decode and next-state wires
  logic                w_hit;
  logic [5:0]          w_off;
  logic                w_wr;
  logic                w_cfg_wr_ok;
  logic                w_filt_wr;
  logic                w_lock_wr;
  logic [NUM_PINS-1:0] w_edge_clr;
  logic [NUM_PINS-1:0] w_filt_nxt;
  logic [FILT_W-1:0]   w_cnt_nxt [NUM_PINS];
  logic [NUM_PINS-1:0] w_rise;
  logic [NUM_PINS-1:0] w_pad_out;
  logic [NUM_PINS-1:0] w_pad_oe;
  logic [31:0]         w_rdata;
  logic                w_unused;

  assign w_hit       = (mem_addr[31:8] == PINMUX_BASE_ADDR[31:8]);
  assign w_off       = mem_addr[7:2];
  assign w_wr        = mem_we & w_hit;
  // CFG and FILT are frozen once the lock bit is set
  assign w_cfg_wr_ok = w_wr & ~r_lock;
  assign w_filt_wr   = w_cfg_wr_ok & (w_off == OFF_FILT);
  assign w_lock_wr   = w_wr & (w_off == OFF_LOCK) & (mem_wdata == 32'h0000_00A5);
  assign w_edge_clr  = (w_wr && (w_off == OFF_EDGE)) ? mem_wdata[NUM_PINS-1:0] : '0;
  assign w_rise      = w_filt_nxt & ~r_filt;
  // Byte-lane address bits carry no meaning for word registers
  assign w_unused    = &{1'b0, mem_addr[1:0]};

  // Per-pin CFG registers: select, force-input and inversion
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PINS; p++) begin
      if (!rst_n) begin
        r_sel[p]   <= RESET_SEL[4*p +: 4];
        r_force[p] <= 1'b0;
        r_inv[p]   <= 1'b0;
      end else if (w_cfg_wr_ok && (w_off == 6'(p))) begin
        r_sel[p]   <= mem_wdata[3:0];
        r_force[p] <= mem_wdata[8];
        r_inv[p]   <= mem_wdata[9];
      end
    end
  end

  // Filter length, lock bit and sticky edge flags (a new set beats a clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt_n <= '0;
      r_lock   <= 1'b0;
      r_edge   <= '0;
    end else begin
      if (w_filt_wr) r_filt_n <= mem_wdata[FILT_W-1:0];
      if (w_lock_wr) r_lock   <= 1'b1;
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
    end
  end

  // Glitch filter next state: the filtered level follows s2 only after s2 has
  // differed from it for N+1 consecutive samples; a FILT write restarts counts
  always_comb begin
    for (int p = 0; p < NUM_PINS; p++) begin
      w_filt_nxt[p] = r_filt[p];
      w_cnt_nxt[p]  = '0;
      if (r_s2[p] != r_filt[p]) begin
        if (r_cnt[p] == r_filt_n) w_filt_nxt[p] = r_s2[p];
        else                      w_cnt_nxt[p]  = r_cnt[p] + 1'b1;
      end
      if (w_filt_wr) w_cnt_nxt[p] = '0;
    end
  end

  // Synchroniser flops and filter state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_filt <= '0;
      for (int p = 0; p < NUM_PINS; p++) r_cnt[p] <= '0;
    end else begin
      r_s1   <= pad_in;
      r_s2   <= r_s1;
      r_filt <= w_filt_nxt;
      for (int p = 0; p < NUM_PINS; p++) r_cnt[p] <= w_cnt_nxt[p];
    end
  end

  // Output mux: only selects below NUM_FUNC match, others leave the pad idle
  always_comb begin
    w_pad_out = '0;
    w_pad_oe  = '0;
    for (int p = 0; p < NUM_PINS; p++) begin
      for (int f = 0; f < NUM_FUNC; f++) begin
        if (r_sel[p] == 4'(f)) begin
          w_pad_out[p] = func_out[p*NUM_FUNC + f] ^ r_inv[p];
          w_pad_oe[p]  = func_oe[p*NUM_FUNC + f] & ~r_force[p];
        end
      end
    end
  end

  // Read mux: zero unless a strobed hit on a mapped offset
  always_comb begin
    w_rdata = '0;
    if (mem_re && w_hit) begin
      for (int p = 0; p < NUM_PINS; p++) begin
        if (w_off == 6'(p)) begin
          w_rdata[3:0] = r_sel[p];
          w_rdata[8]   = r_force[p];
          w_rdata[9]   = r_inv[p];
        end
      end
      case (w_off)
        OFF_FILT: w_rdata[FILT_W-1:0]   = r_filt_n;
        OFF_IN:   w_rdata[NUM_PINS-1:0] = r_filt;
        OFF_EDGE: w_rdata[NUM_PINS-1:0] = r_edge;
        OFF_LOCK: w_rdata[0]            = r_lock;
        default:  ;
      endcase
    end
  end

  assign mem_rdata = w_rdata;
  assign pad_out   = w_pad_out;
  assign pad_oe    = w_pad_oe;
  assign pin_in    = r_filt;

endmodule

// File: tb/tb_pinmux_ctl.sv
// Directed bench for pinmux_ctl: reset state, output mux, filter timing,
// glitch rejection, edge flags and the configuration lock.
module tb_pinmux_ctl;

  localparam logic [31:0] BASE = 32'h40006000;
  localparam int NP = 8;
  localparam int NF = 4;

  logic          clk;
  logic          rst_n;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_rdata;
  logic [NP*NF-1:0] func_out;
  logic [NP*NF-1:0] func_oe;
  logic [NP-1:0] pad_in;
  logic [NP-1:0] pad_out;
  logic [NP-1:0] pad_oe;
  logic [NP-1:0] pin_in;

  int errors = 0;
  int checks = 0;

  pinmux_ctl #(
    .PINMUX_BASE_ADDR(BASE),
    .NUM_PINS(NP),
    .NUM_FUNC(NF),
    .FILT_W(4),
    .RESET_SEL(32'h0000_0001)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .func_out(func_out), .func_oe(func_oe),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .pin_in(pin_in)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge; inputs change and outputs are sampled at the falling edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_addr  = addr;
    mem_wdata = data;
    mem_we    = 1'b1;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    mem_addr = addr;
    mem_re   = 1'b1;
    #1;
    chk(tag, mem_rdata, exp);
    mem_re   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0;
    func_out = '0; func_oe = '0; pad_in = '0;
    func_out[1] = 1'b1;
    func_oe[1]  = 1'b1;
    @(negedge clk);
    tick(2);

    // Reset state: pin0 selects function 1, all others function 0 (driven 0)
    chk("rst_pad_out", 32'(pad_out), 32'h01);
    chk("rst_pad_oe", 32'(pad_oe), 32'h01);
    rst_n = 1'b1;
    tick();
    rd(BASE + 32'h48, 32'h0, "rst_edge");
    rd(BASE + 32'h40, 32'h0, "rst_filt");
    rd(BASE + 32'h4C, 32'h0, "rst_lock");
    rd(BASE + 32'h00, 32'h1, "rst_cfg0");
    rd(BASE + 32'h44, 32'h0, "rst_in");

    // CFG3 = SEL 2, FORCE_IN, INV with function 2 low and enabled
    func_oe[3*NF+2] = 1'b1;
    wr(BASE + 32'h0C, 32'h302);
    chk("cfg3_inv_out", 32'(pad_out[3]), 32'h1);
    chk("cfg3_force_oe", 32'(pad_oe[3]), 32'h0);
    rd(BASE + 32'h0C, 32'h302, "cfg3_read");
    wr(BASE + 32'h0C, 32'h002);
    chk("cfg3_plain_out", 32'(pad_out[3]), 32'h0);
    chk("cfg3_plain_oe", 32'(pad_oe[3]), 32'h1);
    // Out-of-range select idles the pad even with all sources high
    func_out[3*NF +: NF] = '1;
    func_oe[3*NF +: NF]  = '1;
    wr(BASE + 32'h0C, 32'h005);
    chk("sel5_out", 32'(pad_out[3]), 32'h0);
    chk("sel5_oe", 32'(pad_oe[3]), 32'h0);
    rd(BASE + 32'h0C, 32'h005, "sel5_read");
    // Misses and unmapped offsets
    wr(32'h40007000 + 32'h0C, 32'h001);
    rd(BASE + 32'h0C, 32'h005, "miss_write_ignored");
    rd(32'h40007000 + 32'h0C, 32'h0, "miss_read");
    rd(BASE + 32'h50, 32'h0, "unmapped_read");
    func_out = '0;
    func_oe  = '0;
    func_out[1] = 1'b1;
    func_oe[1]  = 1'b1;

    // Filter N=3: pin_in[1] rises exactly 5 edges after s1 capture
    wr(BASE + 32'h40, 32'h3);
    rd(BASE + 32'h40, 32'h3, "filt_read");
    pad_in[1] = 1'b1;
    tick(5);
    chk("filt3_before", 32'(pin_in[1]), 32'h0);
    tick();
    chk("filt3_rise", 32'(pin_in[1]), 32'h1);
    rd(BASE + 32'h48, 32'h2, "edge_pin1");
    rd(BASE + 32'h44, 32'h2, "in_pin1");
    wr(BASE + 32'h48, 32'h2);
    rd(BASE + 32'h48, 32'h0, "edge_pin1_clr");
    pad_in[1] = 1'b0;
    tick(10);
    chk("filt3_fall", 32'(pin_in[1]), 32'h0);

    // 3-cycle pulse is rejected, 4-cycle pulse passes
    pad_in[1] = 1'b1;
    tick(3);
    pad_in[1] = 1'b0;
    tick(12);
    rd(BASE + 32'h48, 32'h0, "glitch3_edge");
    chk("glitch3_in", 32'(pin_in[1]), 32'h0);
    pad_in[1] = 1'b1;
    tick(4);
    pad_in[1] = 1'b0;
    tick(12);
    rd(BASE + 32'h48, 32'h2, "pulse4_edge");
    wr(BASE + 32'h48, 32'h2);

    // Filter N=0: 3 edges; W1C coinciding with a new set leaves the flag set
    wr(BASE + 32'h40, 32'h0);
    pad_in[2] = 1'b1;
    tick(3);
    chk("filt0_rise", 32'(pin_in[2]), 32'h1);
    rd(BASE + 32'h48, 32'h4, "edge_pin2");
    pad_in[2] = 1'b0;
    tick(3);
    chk("filt0_fall", 32'(pin_in[2]), 32'h0);
    rd(BASE + 32'h48, 32'h4, "edge_pin2_sticky");
    pad_in[2] = 1'b1;
    tick(2);
    chk("filt0_before", 32'(pin_in[2]), 32'h0);
    wr(BASE + 32'h48, 32'h4);
    chk("filt0_rise2", 32'(pin_in[2]), 32'h1);
    rd(BASE + 32'h48, 32'h4, "edge_set_wins");
    wr(BASE + 32'h48, 32'h4);
    rd(BASE + 32'h48, 32'h0, "edge_idle_clr");

    // Lock: wrong key ignored, right key freezes CFG and FILT
    wr(BASE + 32'h40, 32'h3);
    wr(BASE + 32'h4C, 32'h5A);
    rd(BASE + 32'h4C, 32'h0, "lock_bad_key");
    wr(BASE + 32'h4C, 32'hA5);
    rd(BASE + 32'h4C, 32'h1, "lock_set");
    mem_addr = BASE + 32'h4C;
    #1;
    chk("read_no_strobe", mem_rdata, 32'h0);
    wr(BASE + 32'h0C, 32'h001);
    rd(BASE + 32'h0C, 32'h005, "lock_cfg_frozen");
    wr(BASE + 32'h40, 32'h7);
    rd(BASE + 32'h40, 32'h3, "lock_filt_frozen");
    pad_in[3] = 1'b1;
    tick(6);
    rd(BASE + 32'h48, 32'h8, "lock_edge_set");
    wr(BASE + 32'h48, 32'h8);
    rd(BASE + 32'h48, 32'h0, "lock_edge_clr");

    // Reset in the middle of a filter count on pin 4 (cnt reaches 2)
    pad_in[4] = 1'b1;
    tick(4);
    rst_n  = 1'b0;
    pad_in = '0;
    tick();
    rst_n  = 1'b1;
    tick();
    rd(BASE + 32'h4C, 32'h0, "post_rst_lock");
    rd(BASE + 32'h40, 32'h0, "post_rst_filt");
    rd(BASE + 32'h44, 32'h0, "post_rst_in");
    rd(BASE + 32'h0C, 32'h0, "post_rst_cfg3");
    chk("post_rst_pad_out", 32'(pad_out), 32'h01);
    // Counts restarted: with N=0 a fresh pulse on pin 4 takes exactly 3 edges
    pad_in[4] = 1'b1;
    tick(2);
    chk("post_rst_cnt_before", 32'(pin_in[4]), 32'h0);
    tick();
    chk("post_rst_cnt_rise", 32'(pin_in[4]), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
